// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vending_pkg
//  Purpose  : Shared FSM encoding, default prices, coin codes and 7-segment
//             patterns for the drink vending machine board.
//  Revision : 1.0  initial release
// ============================================================================
package vending_pkg;

    typedef enum logic [2:0] {
        FREE       = 3'd0,
        TEA_0      = 3'd1,
        COFFEE_0   = 3'd2,
        CHOC_0     = 3'd3,
        MORE_MONEY = 3'd4,
        DELIVERED  = 3'd5
    } vm_state_t;

    localparam int c_price_tea    = 2;
    localparam int c_price_coffee = 3;
    localparam int c_price_choc   = 4;

    localparam logic [2:0] c_coin_1 = 3'd1;
    localparam logic [2:0] c_coin_2 = 3'd2;
    localparam logic [2:0] c_coin_5 = 3'd5;

    // Segment vectors are {a,b,c,d,e,f,g}, active-low.
    localparam logic [6:0] c_seg_blank = 7'b1111111;

    function automatic logic coin_legal(input logic [2:0] code);
        return (code == c_coin_1) || (code == c_coin_2) || (code == c_coin_5);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_mux
//  Purpose  : Time-multiplexed 4-digit 7-segment driver with registered
//             anode and cathode outputs.
//  Revision : 1.0  initial release
// ============================================================================
module seg_display_mux
    import vending_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_digit0,
    input  logic [3:0] i_digit1,
    input  logic [3:0] i_digit2,
    input  logic [3:0] i_digit3,
    input  logic [3:0] i_blank,
    output logic [6:0] o_seg,
    output logic [3:0] o_an
);

    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [c_cnt_w-1:0] r_div;
    logic [1:0]         r_slot;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic               w_tick;
    logic [1:0]         w_slot_nxt;
    logic [3:0]         w_digit;
    logic               w_blank;

    assign w_tick     = (r_div == c_cnt_w'(REFRESH_DIV - 1));
    assign w_slot_nxt = w_tick ? r_slot + 2'd1 : r_slot;

    // Decode from the upcoming slot so anode and cathodes switch together.
    always_comb begin
        w_digit = i_digit0;
        w_blank = i_blank[0];
        case (w_slot_nxt)
            2'd1:    begin w_digit = i_digit1; w_blank = i_blank[1]; end
            2'd2:    begin w_digit = i_digit2; w_blank = i_blank[2]; end
            2'd3:    begin w_digit = i_digit3; w_blank = i_blank[3]; end
            default: begin w_digit = i_digit0; w_blank = i_blank[0]; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_slot <= 2'd0;
            r_an   <= 4'b1110;
            r_seg  <= seg_decode(4'd0);
        end else begin
            r_div  <= w_tick ? '0 : r_div + 1'b1;
            r_slot <= w_slot_nxt;
            r_an   <= ~(4'b0001 << w_slot_nxt);
            r_seg  <= w_blank ? c_seg_blank : seg_decode(w_digit);
        end
    end

    assign o_seg = r_seg;
    assign o_an  = r_an;

endmodule
`default_nettype wire

// File: rtl/vending_machine_board.sv
`default_nettype none
// ============================================================================
//  Module   : vending_machine_board
//  Purpose  : Board top for a tea/coffee/chocolate vending machine; define
//             VM_DEBOUNCE_EN to debounce the product buttons.
//  Revision : 1.0  initial release
// ============================================================================
module vending_machine_board
    import vending_pkg::*;
#(
    parameter int PRICE_TEA       = c_price_tea,
    parameter int PRICE_COFFEE    = c_price_coffee,
    parameter int PRICE_CHOC      = c_price_choc,
    parameter int REFRESH_DIV     = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    input  logic [2:0] Money_in,
    output logic       product1,
    output logic       product2,
    output logic       product3,
    output logic       delivered,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       an0,
    output logic       an1,
    output logic       an2,
    output logic       an3
);

`ifdef VM_DEBOUNCE_EN
    localparam bit c_debounce_en = 1'b1;
`else
    localparam bit c_debounce_en = 1'b0;
`endif

    logic [2:0] r_btn_s1, r_btn_s2, r_btn_prev;
    logic [2:0] r_money_s1, r_money_s2, r_money_prev;
    logic [2:0] w_btn_level, w_btn_press;
    logic       w_coin_evt;

    vm_state_t  r_state, w_state_nxt;
    logic [3:0] r_inserted, w_ins_nxt;
    logic [3:0] r_change, w_chg_nxt;
    logic [3:0] r_price, w_price_nxt;
    logic [1:0] r_prod, w_prod_nxt;
    logic [3:0] w_sum;
    logic [2:0] r_product, w_product_nxt;
    logic       r_delivered;
    logic [6:0] w_seg;
    logic [3:0] w_an;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1     <= '0;
            r_btn_s2     <= '0;
            r_btn_prev   <= '0;
            r_money_s1   <= '0;
            r_money_s2   <= '0;
            r_money_prev <= '0;
        end else begin
            r_btn_s1     <= {BTN3, BTN2, BTN1};
            r_btn_s2     <= r_btn_s1;
            r_btn_prev   <= w_btn_level;
            r_money_s1   <= Money_in;
            r_money_s2   <= r_money_s1;
            r_money_prev <= r_money_s2;
        end
    end

    if (c_debounce_en && DEBOUNCE_CYCLES > 0) begin : g_debounce
        localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
        for (genvar i = 0; i < 3; i++) begin : g_btn
            logic [c_db_w-1:0] r_cnt;
            logic              r_level;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_btn_s2[i] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_w'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_btn_s2[i];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_btn_level[i] = r_level;
        end
    end else begin : g_sync_only
        assign w_btn_level = r_btn_s2;
    end

    assign w_btn_press = w_btn_level & ~r_btn_prev;
    // A code held for many cycles must count once, so only 0 -> legal counts.
    assign w_coin_evt  = (r_money_prev == 3'd0) && coin_legal(r_money_s2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FREE;
            r_inserted  <= 4'd0;
            r_change    <= 4'd0;
            r_price     <= 4'd0;
            r_prod      <= 2'd0;
            r_product   <= 3'b000;
            r_delivered <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_inserted  <= w_ins_nxt;
            r_change    <= w_chg_nxt;
            r_price     <= w_price_nxt;
            r_prod      <= w_prod_nxt;
            r_product   <= w_product_nxt;
            r_delivered <= (w_state_nxt == DELIVERED);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ins_nxt     = r_inserted;
        w_chg_nxt     = r_change;
        w_price_nxt   = r_price;
        w_prod_nxt    = r_prod;
        w_product_nxt = 3'b000;
        w_sum         = r_inserted + {1'b0, r_money_s2};
        case (r_state)
            FREE: begin
                if (w_btn_press[0]) begin
                    w_state_nxt = TEA_0;
                    w_prod_nxt  = 2'd1;
                    w_price_nxt = 4'(PRICE_TEA);
                end else if (w_btn_press[1]) begin
                    w_state_nxt = COFFEE_0;
                    w_prod_nxt  = 2'd2;
                    w_price_nxt = 4'(PRICE_COFFEE);
                end else if (w_btn_press[2]) begin
                    w_state_nxt = CHOC_0;
                    w_prod_nxt  = 2'd3;
                    w_price_nxt = 4'(PRICE_CHOC);
                end
            end
            TEA_0, COFFEE_0, CHOC_0, MORE_MONEY: begin
                if (w_coin_evt) begin
                    w_ins_nxt = w_sum;
                    if (w_sum >= r_price) begin
                        w_state_nxt = DELIVERED;
                        w_chg_nxt   = w_sum - r_price;
                    end else begin
                        w_state_nxt = MORE_MONEY;
                    end
                end
            end
            DELIVERED: w_state_nxt = DELIVERED;
            default:   w_state_nxt = FREE;
        endcase
        if (w_state_nxt == DELIVERED) begin
            case (w_prod_nxt)
                2'd1:    w_product_nxt = 3'b001;
                2'd2:    w_product_nxt = 3'b010;
                2'd3:    w_product_nxt = 3'b100;
                default: w_product_nxt = 3'b000;
            endcase
        end
    end

    seg_display_mux #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_display (
        .clk      (clk),
        .rst      (reset),
        .i_digit0 (r_inserted),
        .i_digit1 (4'd0),
        .i_digit2 ({2'b00, r_prod}),
        .i_digit3 (r_change),
        .i_blank  ({1'b0, r_state == FREE, 1'b1, 1'b0}),
        .o_seg    (w_seg),
        .o_an     (w_an)
    );

    assign {product3, product2, product1} = r_product;
    assign delivered                      = r_delivered;
    assign {a, b, c, d, e, f, g}          = w_seg;
    assign {an3, an2, an1, an0}           = w_an;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_board.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vending_machine_board
//  Purpose  : Self-checking bench for vending_machine_board against a
//             transaction-level model of the machine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vending_machine_board;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       BTN1 = 1'b0, BTN2 = 1'b0, BTN3 = 1'b0;
    logic [2:0] Money_in = 3'd0;
    logic       product1, product2, product3, delivered;
    logic       a, b, c, d, e, f, g;
    logic       an0, an1, an2, an3;

    int checks = 0;
    int errors = 0;

    // Model: selected product (0 = none), its price, money, change, delivered.
    int m_prod, m_price, m_ins, m_chg;
    bit m_del;

    vending_machine_board dut (
        .clk (clk), .reset (reset),
        .BTN1 (BTN1), .BTN2 (BTN2), .BTN3 (BTN3), .Money_in (Money_in),
        .product1 (product1), .product2 (product2), .product3 (product3),
        .delivered (delivered),
        .a (a), .b (b), .c (c), .d (d), .e (e), .f (f), .g (g),
        .an0 (an0), .an1 (an1), .an2 (an2), .an3 (an3)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int v, input bit blank);
        if (blank) return 7'b1111111;
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_digit(input int idx, input string tag, output logic [6:0] seg);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << idx);
        found = 1'b0;
        seg   = 7'bxxxxxxx;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if ({an3, an2, an1, an0} === want) begin
                seg   = {a, b, c, d, e, f, g};
                found = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL %s_anode_timeout observed %b expected %b", tag, {an3, an2, an1, an0}, want);
        end
    endtask

    task automatic check_all(input string tag);
        logic [6:0] seg;
        logic [2:0] exp_p;
        exp_p = m_del ? 3'(1 << (m_prod - 1)) : 3'b000;
        check({tag, "_delivered"}, 16'(delivered), 16'(m_del));
        check({tag, "_products"}, 16'({product3, product2, product1}), 16'(exp_p));
        read_digit(0, tag, seg);
        check({tag, "_digit0"}, 16'(seg), 16'(exp_seg(m_ins, 1'b0)));
        read_digit(2, tag, seg);
        check({tag, "_digit2"}, 16'(seg), 16'(exp_seg(m_prod, m_prod == 0)));
        read_digit(3, tag, seg);
        check({tag, "_digit3"}, 16'(seg), 16'(exp_seg(m_chg, 1'b0)));
    endtask

    task automatic mdl_reset();
        m_prod = 0; m_price = 0; m_ins = 0; m_chg = 0; m_del = 1'b0;
    endtask

    task automatic mdl_press(input logic [2:0] mask);
        if (m_prod == 0) begin
            if (mask[0])      begin m_prod = 1; m_price = 2; end
            else if (mask[1]) begin m_prod = 2; m_price = 3; end
            else if (mask[2]) begin m_prod = 3; m_price = 4; end
        end
    endtask

    task automatic mdl_coin(input int code);
        if (m_prod != 0 && !m_del && (code == 1 || code == 2 || code == 5)) begin
            m_ins += code;
            if (m_ins >= m_price) begin
                m_del = 1'b1;
                m_chg = m_ins - m_price;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {BTN3, BTN2, BTN1} = 3'b000;
        Money_in = 3'd0;
        @(negedge clk);
        reset = 1'b0;
        mdl_reset();
    endtask

    task automatic press(input logic [2:0] mask);
        @(negedge clk);
        {BTN3, BTN2, BTN1} = mask;
        repeat (4) @(negedge clk);
        {BTN3, BTN2, BTN1} = 3'b000;
        repeat (4) @(negedge clk);
        mdl_press(mask);
    endtask

    task automatic coin(input int code);
        @(negedge clk);
        Money_in = 3'(code);
        repeat (6) @(negedge clk);
        Money_in = 3'd0;
        repeat (6) @(negedge clk);
        mdl_coin(code);
    endtask

    initial begin
        logic [6:0] seg;
        int n_coins;
        mdl_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        do_reset();
        check("reset_anodes", 16'({an3, an2, an1, an0}), 16'(4'b1110));
        check_all("reset");
        read_digit(1, "reset", seg);
        check("reset_digit1", 16'(seg), 16'(7'b1111111));

        press(3'b001);
        coin(2);
        check_all("tea_exact");

        do_reset();
        press(3'b001);
        coin(5);
        check_all("tea_change");

        do_reset();
        press(3'b100);
        coin(1);
        check_all("choc_c1");
        coin(2);
        check_all("choc_c2");
        coin(1);
        check_all("choc_c3");

        do_reset();
        coin(5);
        check_all("free_coin");
        press(3'b010);
        coin(3);
        coin(7);
        check_all("illegal_codes");

        do_reset();
        press(3'b011);
        check_all("btn_priority");

        do_reset();
        press(3'b010);
        coin(2);
        check_all("abort_pre");
        do_reset();
        check_all("abort_post");

        for (int t = 0; t < 15; t++) begin
            do_reset();
            if ($urandom_range(0, 1) == 1) coin($urandom_range(1, 7));
            press(3'($urandom_range(1, 7)));
            check_all($sformatf("rnd%0d_sel", t));
            n_coins = $urandom_range(2, 6);
            for (int k = 0; k < n_coins; k++) begin
                coin($urandom_range(1, 7));
                if ($urandom_range(0, 3) == 0) press(3'($urandom_range(1, 7)));
                check_all($sformatf("rnd%0d_c%0d", t, k));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vending_machine_board.md
Name: vending_machine_board

Overview:
- Board-level top for a three-product drink vending machine: tea, coffee and hot chocolate.
- Takes push buttons and a coded coin input, runs the selection/payment FSM and drives product/delivered indicators.
- Drives a 4-digit multiplexed 7-segment display:
  - digit0: inserted money.
  - digit2: selected product number.
  - digit3: change.
- Sits directly on the FPGA pins; single clock domain.

Parameters:
- PRICE_TEA, 2, tea price in zl.
- PRICE_COFFEE, 3, coffee price in zl.
- PRICE_CHOC, 4, hot chocolate price in zl.
- REFRESH_DIV, 4, clk cycles per display digit slot (set to 100000 for the board).
- DEBOUNCE_CYCLES, 3, stable cycles required for a button press (used only with DEBOUNCE_EN).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- BTN1  in  1  select tea.
- BTN2  in  1  select coffee.
- BTN3  in  1  select hot chocolate.
- Money_in  in  3  coin code equal to the coin value in zl:
  - Legal codes: 1, 2, 5.
  - 0 means no coin.
  - Other codes are ignored.
- product1  out  1  tea dispensed.
- product2  out  1  coffee dispensed.
- product3  out  1  hot chocolate dispensed.
- delivered  out  1  product delivered.
- a,b,c,d,e,f,g  out  1 each  segment cathodes, active-low.
- an0,an1,an2,an3  out  1 each  digit anodes, active-low, one low at a time.

Behaviour:
- Reset:
  - FSM enters FREE; inserted = 0, change = 0, no product latched.
  - product1..3 = 0, delivered = 0.
  - Refresh counter = 0; digit slot = 0, so an0 is low and the others high.
  - Display shows "0" on digit0 and digit3; digits 1 and 2 are blank.
  - Reset mid-transaction aborts it; no delivery occurs.
- Inputs:
  - BTN1..3 and Money_in pass through a 2-flop synchronizer.
  - Button press = rising edge of the synchronized level.
  - Coin event = synchronized Money_in goes from 0 to a legal nonzero code. A coin code held for many cycles counts once.
- FSM states: FREE, TEA_0, COFFEE_0, CHOC_0, MORE_MONEY, DELIVERED.
- FREE:
  - A button press latches the product and its price, then moves to TEA_0, COFFEE_0 or CHOC_0.
  - Simultaneous presses: BTN1 wins over BTN2, which wins over BTN3.
  - Coins in FREE are ignored.
- X_0 and MORE_MONEY:
  - On a coin event, inserted is updated to inserted + value.
  - If the new inserted value is >= price, go to DELIVERED and set change = inserted - price in the same update.
  - Otherwise go to MORE_MONEY.
  - Buttons are ignored.
- DELIVERED:
  - delivered = 1 and the latched productN = 1.
  - Holds until reset; further coins and buttons are ignored.
- Width: inserted and change are 4 bits. inserted never exceeds price - 1 + 5 = 8, so no saturation is needed.
- Latency:
  - Coin edge at the pins to updated inserted/delivered: 3 clk edges (2 synchronizer + 1 FSM).
  - Button press to state change: 3 clk edges without DEBOUNCE_EN.
- All outputs are registered.
- Display refresh:
  - Divider ticks every REFRESH_DIV cycles.
  - Digit slot rotates 0→1→2→3→0 on each tick.
  - digit1 is always blank; digit2 is blank in FREE.
- Segment patterns: standard hex-digit patterns, active-low (e.g. 0 = a..g 0000001), all-ones for blank.

Optional Feature:
- Macro: VM_DEBOUNCE_EN.
- Defined:
  - Each synchronized button must be stable for DEBOUNCE_CYCLES consecutive cycles before its debounced level changes.
  - The press edge is taken from the debounced level.
  - Button latency = 3 + DEBOUNCE_CYCLES.
- Undefined: synchronizer only. Coins are never debounced.

Decomposition:
- Package vending_pkg holds:
  - FSM state encoding.
  - Default prices.
  - Legal coin codes.
  - Segment patterns for 0-9 and blank.
- One natural sub-module: seg_display_mux. It contains the refresh divider, digit slot counter, anode decode and BCD-to-segment decode, with four 4-bit digit values plus blank flags as inputs.

Test Plan:
- Reset: assert reset for 1 cycle → product1..3 = 0, delivered = 0, digit0/digit3 show 0.
- Tea exact: BTN1 = 1, then 100 ns later Money_in = 2 held 60 ns → product1 = 1, delivered = 1, inserted 2, change 0.
- Tea with change: BTN1 = 1, then Money_in = 5 → product1 = 1, delivered = 1, digit0 = 5, digit3 = 3.
- Chocolate multi-coin: BTN3, then coins 1, 2, 1 (returning to 0 between) → MORE_MONEY after coins 1 and 2, DELIVERED after the third coin, product3 = 1, change 0.
- Ignored inputs:
  - Coin 5 in FREE → inserted stays 0.
  - Money_in = 3 or 7 → ignored.
  - BTN1 + BTN2 together → tea selected.
- Abort: BTN2 then coin 2, then reset → delivered never asserts; FSM in FREE with inserted 0.
